// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing defaults, clear FSM states and colour type for vga_fb_display
package vga_pkg;

  localparam int DEF_HD      = 1280;
  localparam int DEF_HF      = 48;
  localparam int DEF_HR      = 112;
  localparam int DEF_HB      = 248;
  localparam int DEF_VD      = 1024;
  localparam int DEF_VF      = 1;
  localparam int DEF_VR      = 3;
  localparam int DEF_VB      = 38;
  localparam int DEF_BPP     = 1;
  localparam int DEF_COLOR_W = 12;

  localparam int DEF_HTOT   = DEF_HD + DEF_HF + DEF_HR + DEF_HB;
  localparam int DEF_VTOT   = DEF_VD + DEF_VF + DEF_VR + DEF_VB;
  localparam int DEF_ADDR_W = $clog2(DEF_HD * DEF_VD);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  typedef logic [DEF_COLOR_W-1:0] color_t;

  function automatic int ctr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// rtl/vga_fb_ram.sv - simple dual-port framebuffer RAM, one write port, one registered read port
module vga_fb_ram #(
  parameter int W     = 1,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // No reset so the array maps onto block RAM; a same-address read returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_fb_display.sv
// rtl/vga_fb_display.sv - indexed framebuffer VGA engine with palette, clear engine and write port
module vga_fb_display
  import vga_pkg::*;
#(
  parameter int   HD      = DEF_HD,
  parameter int   HF      = DEF_HF,
  parameter int   HR      = DEF_HR,
  parameter int   HB      = DEF_HB,
  parameter int   VD      = DEF_VD,
  parameter int   VF      = DEF_VF,
  parameter int   VR      = DEF_VR,
  parameter int   VB      = DEF_VB,
  parameter int   BPP     = DEF_BPP,
  parameter int   COLOR_W = DEF_COLOR_W,
  parameter logic HS_POL  = 1'b1,
  parameter logic VS_POL  = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      arstn_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [$clog2(HD+1)-1:0]   wr_x_i,
  input  logic [$clog2(VD+1)-1:0]   wr_y_i,
  input  logic [BPP-1:0]            wr_idx_i,
  output logic                      wr_err_o,
  input  logic                      clear_i,
  input  logic [BPP-1:0]            clear_idx_i,
  output logic                      clear_busy_o,
  input  logic                      pal_we_i,
  input  logic [BPP-1:0]            pal_addr_i,
  input  logic [COLOR_W-1:0]        pal_data_i,
  output logic                      VGA_HS_o,
  output logic                      VGA_VS_o,
  output logic [COLOR_W-1:0]        RGB_o,
  output logic                      frame_start_o
);

  localparam int HTOT   = HD + HF + HR + HB;
  localparam int VTOT   = VD + VF + VR + VB;
  localparam int NPIX   = HD * VD;
  localparam int ADDR_W = $clog2(NPIX);
  localparam int HCW    = ctr_w(HTOT);
  localparam int VCW    = ctr_w(VTOT);
  localparam int XW     = $clog2(HD + 1);
  localparam int YW     = $clog2(VD + 1);
  localparam int NPAL   = 2 ** BPP;

  logic [HCW-1:0] hcount_q, hcount_d;
  logic [VCW-1:0] vcount_q, vcount_d;
  logic           h_wrap, v_wrap;

  always_comb begin
    h_wrap   = (hcount_q == HCW'(HTOT - 1));
    v_wrap   = (vcount_q == VCW'(VTOT - 1));
    hcount_d = h_wrap ? '0 : hcount_q + 1'b1;
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
    end
  end

  logic              h_act, v_act, act_raw, hs_raw, vs_raw;
  logic [ADDR_W-1:0] rd_addr;

  always_comb begin
    hs_raw  = (hcount_q < HCW'(HR));
    vs_raw  = (vcount_q < VCW'(VR));
    h_act   = (hcount_q >= HCW'(HR + HB)) && (hcount_q <= HCW'(HR + HB + HD - 1));
    v_act   = (vcount_q >= VCW'(VR + VB)) && (vcount_q <= VCW'(VR + VB + VD - 1));
    act_raw = h_act && v_act;
    rd_addr = '0;
    if (act_raw) begin
      rd_addr = ADDR_W'(vcount_q - VCW'(VR + VB)) * ADDR_W'(HD)
              + ADDR_W'(hcount_q - HCW'(HR + HB));
    end
  end

  clr_state_e        state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [BPP-1:0]    clr_idx_q;
  logic              wr_err_q;
  logic              wr_fire, wr_in_range;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr, wr_addr;
  logic [BPP-1:0]    ram_wdata, rd_idx;

  always_comb begin
    wr_fire     = wr_valid_i && (state_q == ST_IDLE);
    wr_in_range = (wr_x_i < XW'(HD)) && (wr_y_i < YW'(VD));
    wr_addr     = ADDR_W'(wr_y_i) * ADDR_W'(HD) + ADDR_W'(wr_x_i);
    // The clear engine owns the write port for its whole run; producers are stalled via ready.
    ram_we      = (state_q == ST_CLEAR) || (wr_fire && wr_in_range);
    ram_waddr   = (state_q == ST_CLEAR) ? clr_cnt_q : wr_addr;
    ram_wdata   = (state_q == ST_CLEAR) ? clr_idx_q : wr_idx_i;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
      clr_idx_q <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      wr_err_q <= wr_fire && !wr_in_range;
      case (state_q)
        ST_IDLE: begin
          if (clear_i) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= clear_idx_i;
            clr_cnt_q <= '0;
          end
        end
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == ADDR_W'(NPIX - 1)) begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  vga_fb_ram #(
    .W    (BPP),
    .DEPTH(NPIX),
    .AW   (ADDR_W)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .raddr_i(rd_addr),
    .rdata_o(rd_idx)
  );

  logic [COLOR_W-1:0] pal_q [NPAL];

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int i = 0; i < NPAL; i++) begin
        pal_q[i] <= (i == 0) ? '0 : '1;
      end
    end else if (pal_we_i) begin
      pal_q[pal_addr_i] <= pal_data_i;
    end
  end

  logic               act1_q, hs1_q, vs1_q;
  logic               act2_q, hs2_q, vs2_q;
  logic [COLOR_W-1:0] col2_q, rgb_q;
  logic               hs_out_q, vs_out_q, frame_start_q;

  // Sync/active travel alongside RAM read (1), palette lookup (2) and output register (3).
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      act1_q        <= 1'b0;
      hs1_q         <= 1'b0;
      vs1_q         <= 1'b0;
      act2_q        <= 1'b0;
      hs2_q         <= 1'b0;
      vs2_q         <= 1'b0;
      col2_q        <= '0;
      rgb_q         <= '0;
      hs_out_q      <= ~HS_POL;
      vs_out_q      <= ~VS_POL;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      act1_q        <= act_raw;
      hs1_q         <= hs_raw;
      vs1_q         <= vs_raw;
      act2_q        <= act1_q;
      hs2_q         <= hs1_q;
      vs2_q         <= vs1_q;
      col2_q        <= pal_q[rd_idx];
      rgb_q         <= act2_q ? col2_q : '0;
      hs_out_q      <= hs2_q ? HS_POL : ~HS_POL;
      vs_out_q      <= vs2_q ? VS_POL : ~VS_POL;
      frame_start_q <= h_wrap && v_wrap;
    end
  end

  assign wr_ready_o    = (state_q == ST_IDLE);
  assign clear_busy_o  = (state_q == ST_CLEAR);
  assign wr_err_o      = wr_err_q;
  assign VGA_HS_o      = hs_out_q;
  assign VGA_VS_o      = vs_out_q;
  assign RGB_o         = rgb_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_fb_display.sv
// tb/tb_vga_fb_display.sv - randomized scoreboard bench for vga_fb_display on a tiny 8x4 raster
module tb_vga_fb_display;

  localparam int HD = 8, HF = 2, HR = 2, HB = 2;
  localparam int VD = 4, VF = 1, VR = 1, VB = 1;
  localparam int BPP = 1, CW = 12;
  localparam int HTOT = 14, VTOT = 7, FRAME = 98, NPIX = 32;

  logic          clk = 1'b0;
  logic          arstn = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [3:0]    wr_x = '0;
  logic [2:0]    wr_y = '0;
  logic [0:0]    wr_idx = '0;
  logic          wr_err;
  logic          clear = 1'b0;
  logic [0:0]    clear_idx = '0;
  logic          clear_busy;
  logic          pal_we = 1'b0;
  logic [0:0]    pal_addr = '0;
  logic [CW-1:0] pal_data = '0;
  logic          hs, vs, frame_start;
  logic [CW-1:0] rgb;

  always #5 clk = ~clk;

  vga_fb_display #(
    .HD(HD), .HF(HF), .HR(HR), .HB(HB),
    .VD(VD), .VF(VF), .VR(VR), .VB(VB),
    .BPP(BPP), .COLOR_W(CW), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk_i        (clk),
    .arstn_i      (arstn),
    .wr_valid_i   (wr_valid),
    .wr_ready_o   (wr_ready),
    .wr_x_i       (wr_x),
    .wr_y_i       (wr_y),
    .wr_idx_i     (wr_idx),
    .wr_err_o     (wr_err),
    .clear_i      (clear),
    .clear_idx_i  (clear_idx),
    .clear_busy_o (clear_busy),
    .pal_we_i     (pal_we),
    .pal_addr_i   (pal_addr),
    .pal_data_i   (pal_data),
    .VGA_HS_o     (hs),
    .VGA_VS_o     (vs),
    .RGB_o        (rgb),
    .frame_start_o(frame_start)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: raster position from elapsed cycles, framebuffer as a plain array.
  int  cyc;
  int  fb [NPIX];
  bit  fb_known [NPIX];
  int  pal [2];
  int  clear_left;
  int  clear_val;
  bit  err_exp;
  bit  fs_exp;

  typedef struct {
    bit hs;
    bit vs;
    bit act;
    bit known;
    int idx;
    int rgb;
  } pix_t;

  pix_t exp_q[$];
  pix_t prev;
  bit   have_prev;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) begin
      fb[i] = 0;
      fb_known[i] = 1'b0;
    end
  end

  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cyc        = 0;
      clear_left = 0;
      clear_val  = 0;
      err_exp    = 1'b0;
      fs_exp     = 1'b0;
      have_prev  = 1'b0;
      exp_q.delete();
      pal[0] = 0;
      pal[1] = 12'hFFF;
    end else begin : model
      int   h, v, x, y, a;
      pix_t cur, e;
      // A pixel sampled last cycle is coloured with the palette as it stood before this edge.
      if (have_prev) begin
        e     = prev;
        e.rgb = prev.act ? pal[prev.idx] : 0;
        exp_q.push_back(e);
      end
      h = cyc % HTOT;
      v = (cyc / HTOT) % VTOT;
      x = h - (HR + HB);
      y = v - (VR + VB);
      cur.hs    = (h < HR);
      cur.vs    = (v < VR);
      cur.act   = (x >= 0) && (x < HD) && (y >= 0) && (y < VD);
      cur.idx   = 0;
      cur.known = 1'b1;
      cur.rgb   = 0;
      if (cur.act) begin
        cur.idx   = fb[y * HD + x];
        cur.known = fb_known[y * HD + x];
      end
      prev      = cur;
      have_prev = 1'b1;
      fs_exp    = ((cyc + 1) % FRAME) == 0;
      err_exp   = 1'b0;
      if (wr_valid && clear_left == 0) begin
        if (wr_x < HD && wr_y < VD) begin
          a = int'(wr_y) * HD + int'(wr_x);
          fb[a] = wr_idx;
          fb_known[a] = 1'b1;
        end else begin
          err_exp = 1'b1;
        end
      end
      if (clear_left > 0) begin
        a = NPIX - clear_left;
        fb[a] = clear_val;
        fb_known[a] = 1'b1;
        clear_left--;
      end else if (clear) begin
        clear_left = NPIX;
        clear_val  = clear_idx;
      end
      if (pal_we) pal[pal_addr] = pal_data;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (arstn) begin : monitor
      pix_t e;
      chk("wr_ready", wr_ready, clear_left == 0);
      chk("clear_busy", clear_busy, clear_left != 0);
      chk("wr_err", wr_err, err_exp);
      chk("frame_start", frame_start, fs_exp);
      if (cyc < 3) begin
        chk("hs_pipe_fill", hs, 0);
        chk("vs_pipe_fill", vs, 0);
        chk("rgb_pipe_fill", rgb, 0);
      end else if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 0, 1);
      end else begin
        e = exp_q.pop_front();
        chk("hs", hs, e.hs);
        chk("vs", vs, e.vs);
        if (e.known) chk("rgb", rgb, e.rgb);
      end
    end
  end

  task automatic wr(input int x, input int y, input int idx);
    int n;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_x = 4'(x);
    wr_y = 3'(y);
    wr_idx = 1'(idx);
    n = 0;
    while (!wr_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wr_stall_bound", n < 100, 1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic start_clear(input int idx);
    @(negedge clk);
    clear = 1'b1;
    clear_idx = 1'(idx);
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (clear_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("clear_done_bound", n < 100, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hs"}, hs, 0);
    chk({tag, "_vs"}, vs, 0);
    chk({tag, "_rgb"}, rgb, 0);
    chk({tag, "_err"}, wr_err, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_ready"}, wr_ready, 1);
    chk({tag, "_busy"}, clear_busy, 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    int n;
    #1 arstn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    arstn = 1'b1;
    repeat (210) @(negedge clk);

    // Clear to 0 with a simultaneous write that the fill then overwrites.
    @(negedge clk);
    clear = 1'b1; clear_idx = 1'b0;
    wr_valid = 1'b1; wr_x = 4'd5; wr_y = 3'd2; wr_idx = 1'b1;
    @(negedge clk);
    clear = 1'b0; wr_valid = 1'b0;
    wait_idle();
    wr(3, 1, 1);
    repeat (110) @(negedge clk);

    wr(8, 0, 1);
    wr(0, 4, 1);
    repeat (110) @(negedge clk);

    // Fill with 1 while a write is held waiting for ready.
    start_clear(1);
    fork
      begin
        n = 0;
        while (clear_busy && n < 100) begin
          n++;
          @(negedge clk);
        end
        chk("clear_len", n, 32);
      end
      wr(2, 2, 0);
    join
    repeat (110) @(negedge clk);

    repeat (40) @(negedge clk);
    @(negedge clk);
    pal_we = 1'b1; pal_addr = 1'b1; pal_data = 12'h0F0;
    @(negedge clk);
    pal_we = 1'b0;
    repeat (110) @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: wr($urandom_range(0, 9), $urandom_range(0, 4), $urandom_range(0, 1));
        4: begin
          @(negedge clk);
          pal_we = 1'b1; pal_addr = 1'($urandom_range(0, 1)); pal_data = 12'($urandom);
          @(negedge clk);
          pal_we = 1'b0;
        end
        5: if ($urandom_range(0, 9) == 0) start_clear($urandom_range(0, 1));
        default: @(negedge clk);
      endcase
    end
    wait_idle();

    // Reset ten cycles into a fill: first ten words hold the fill, the rest keep zero.
    start_clear(0);
    wait_idle();
    start_clear(1);
    repeat (10) @(negedge clk);
    #1 arstn = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    arstn = 1'b1;
    repeat (110) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
